// File: rtl/shiftregister_pkg.sv
// Shared definitions for the universal shift register.
// Holds the operation-select encodings, the burst FSM state type and a
// helper that tells whether a mode actually moves bits (shift or rotate).
package shiftregister_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // True for the modes a burst repeats; hold, load and the reserved codes
  // complete a burst immediately without entering SHIFT.
  function automatic logic is_step_mode(input logic [MODE_W-1:0] m);
    return (m == MODE_SHR) || (m == MODE_SHL) ||
           (m == MODE_ROR) || (m == MODE_ROL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One step of the shift register datapath, purely combinational.
// Shared by the free-running path and the burst engine.
// Ports:
//   cur_val  - current register contents
//   mode     - operation select (reserved codes hold)
//   sin_right- fill bit entering bit 0 on a right shift
//   sin_left - fill bit entering bit WIDTH-1 on a left shift
//   preset   - parallel load value
//   next_val - register contents after one step
// "Right" moves bit i to bit i+1; "left" moves bit i to bit i-1.
module shift_step
  import shiftregister_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]  cur_val,
  input  logic [MODE_W-1:0] mode,
  input  logic              sin_right,
  input  logic              sin_left,
  input  logic [WIDTH-1:0]  preset,
  output logic [WIDTH-1:0]  next_val
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    next_val = cur_val;
    case (mode)
      MODE_SHR:  next_val = {cur_val[WIDTH-2:0], sin_right};
      MODE_SHL:  next_val = {sin_left, cur_val[WIDTH-1:1]};
      MODE_LOAD: next_val = preset;
      MODE_ROR:  next_val = {cur_val[WIDTH-2:0], cur_val[WIDTH-1]};
      MODE_ROL:  next_val = {cur_val[0], cur_val[WIDTH-1:1]};
      default:   next_val = cur_val;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register with free-running per-cycle control and a
// counted burst engine.
// Ports:
//   clockpulse       - clock, rising edge
//   clear            - synchronous active-high reset, highest priority
//   mode             - operation select (see shiftregister_pkg)
//   start            - burst request, sampled only in IDLE
//   count            - number of steps for a burst
//   serialInputRight - fill bit for right shifts (enters bit 0)
//   serialInputLeft  - fill bit for left shifts (enters bit WIDTH-1)
//   preset           - parallel load value
//   out / notout     - register contents and their complement
//   serialOutRight   - out[WIDTH-1]
//   serialOutLeft    - out[0]
//   busy             - high while a burst is stepping
//   done             - one-cycle pulse when a burst completes
module universal_shift_register
  import shiftregister_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clockpulse,
  input  logic                   clear,
  input  logic [MODE_W-1:0]      mode,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   serialInputRight,
  input  logic                   serialInputLeft,
  input  logic [WIDTH-1:0]       preset,
  output logic [WIDTH-1:0]       out,
  output logic [WIDTH-1:0]       notout,
  output logic                   serialOutRight,
  output logic                   serialOutLeft,
  output logic                   busy,
  output logic                   done
);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       out_q, out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [MODE_W-1:0]      mode_lat_q, mode_lat_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;

  logic [MODE_W-1:0]      step_mode;
  logic [WIDTH-1:0]       step_next;

  // While a burst runs the latched mode drives the datapath; the live mode
  // input is ignored until the FSM is back in IDLE.
  assign step_mode = (state_q == ST_SHIFT) ? mode_lat_q : mode;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .cur_val  (out_q),
    .mode     (step_mode),
    .sin_right(serialInputRight),
    .sin_left (serialInputLeft),
    .preset   (preset),
    .next_val (step_next)
  );

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mode_lat_d  = mode_lat_q;
    remaining_d = remaining_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_lat_d = mode;
          if (count == '0 || !is_step_mode(mode)) begin
            // Degenerate burst: finishes on the accepting edge. Only a load
            // changes the register here.
            done_d = 1'b1;
            if (mode == MODE_LOAD) out_d = step_next;
          end else begin
            state_d     = ST_SHIFT;
            busy_d      = 1'b1;
            remaining_d = count;
          end
        end else begin
          out_d = step_next;
        end
      end
      ST_SHIFT: begin
        out_d       = step_next;
        remaining_d = remaining_q - COUNT_WIDTH'(1);
        // remaining_q is at least 1 in SHIFT, so the decrement never wraps.
        if (remaining_q == COUNT_WIDTH'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clockpulse) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (clear) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mode_lat_q  <= MODE_HOLD;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mode_lat_q  <= mode_lat_d;
      remaining_q <= remaining_d;
    end
  end

  assign out            = out_q;
  assign notout         = ~out_q;
  assign serialOutRight = out_q[WIDTH-1];
  assign serialOutLeft  = out_q[0];
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
